text_render_ctrl: RTL and testbench
===================================

TEXT_RENDER_CTRL -- requirements
Module: text_render_ctrl

Interface
REQ-001 Parameter SCREEN_W, default 640, screen width in pixels; SHALL be a multiple of 8.
REQ-002 Parameter LEN_W, default 8, width of string length and buffer address.
REQ-003 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle request to render a string; SHALL be sampled only in IDLE.
REQ-006 x0  in  10  start pixel column; SHALL be sampled with start and be a multiple of 8.
REQ-007 y0  in  9  start pixel row; SHALL be sampled with start.
REQ-008 len  in  LEN_W  character count; SHALL be sampled with start.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse when a render completes.
REQ-011 rd_en, rd_addr  out  1, LEN_W  text buffer read strobe and address, index 0..len-1.
REQ-012 rd_data  in  7  ASCII character, valid the cycle after rd_en.
REQ-013 dec_char  out  7  registered character driving the external char_decoder.
REQ-014 dec_pixels  in  128  combinational 8x16 bitmap from char_decoder.
REQ-015 px_valid, px_x, px_y, px_on  out  1, 10, 9, 1  pixel write request: coordinates and on/off value.
REQ-016 px_ready  in  1  pixel sink accepts when px_valid and px_ready are both high.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, WAIT, DECODE, DRAW, DONE.
REQ-018 IDLE with start=1 and len>0: SHALL latch x0, y0, len, set index=0, cur_x=x0, cur_y=y0, and go to FETCH.
REQ-019 IDLE with start=1 and len=0: SHALL go to DONE without issuing any read or pixel.
REQ-020 FETCH: SHALL assert rd_en=1 with rd_addr=index for exactly one cycle, then go to WAIT.
REQ-021 WAIT: SHALL register rd_data into dec_char, then go to DECODE.
REQ-022 DECODE: SHALL latch dec_pixels into an internal 128-bit bitmap, clear row/col counters, then go to DRAW.
REQ-023 DRAW: px_valid=1, px_x=cur_x+col, px_y=cur_y+row, px_on=bitmap[127-(row*8+col)], row and col starting at 0.
REQ-024 On each accepted pixel, col SHALL increment; at col=7 it SHALL wrap to 0 and row SHALL increment, giving row-major scan order.
REQ-025 While px_valid=1 and px_ready=0, px_x, px_y and px_on SHALL hold stable.
REQ-026 On acceptance of pixel (row 15, col 7), index SHALL increment and cur_x SHALL advance by 8.
REQ-027 If cur_x+8 >= SCREEN_W on that advance, cur_x SHALL become 0 and cur_y SHALL advance by 16. Wrap of cur_y modulo 512 SHALL be silent.
REQ-028 After the advance, the FSM SHALL go to FETCH if index<len, else to DONE.
REQ-029 DONE: done=1 for one cycle, then IDLE.
REQ-030 start asserted in any state other than IDLE SHALL be ignored.
REQ-031 Latency: start sampled at edge N gives rd_en in cycle N+1 and the first px_valid in cycle N+4.
REQ-032 Cycles per character SHALL be 3 plus 128 accepted pixels; with px_ready tied high this is 131.

Reset
REQ-033 resetn=0 SHALL force, asynchronously, state=IDLE and clear busy, done, rd_en, rd_addr, dec_char, px_valid, px_x, px_y, px_on, the bitmap and all counters.
REQ-034 Reset mid-render SHALL abandon the string with no done pulse; the first start after release SHALL begin a fresh render.

Verification
REQ-035 Basic render: x0=0, y0=0, len=1, buffer[0]="A", px_ready=1 -> 128 pixels in scan order; pixel (x2,y2)=1 and (x0,y0)=0; done in cycle N+132.
REQ-036 Line wrap: SCREEN_W=640, x0=632, y0=0, len=2 -> char 0 at x 632..639; char 1 at x 0..7, y 16..31.
REQ-037 Backpressure: px_ready toggled pseudo-randomly -> no pixel dropped or duplicated; outputs stable while stalled; exactly 128*len handshakes.
REQ-038 Zero length: start with len=0 -> no rd_en and no px_valid; done one cycle after start is sampled.
REQ-039 Reset mid-operation: resetn low during DRAW of char 1 of 3 -> all outputs 0 immediately, no done; after release, a new start renders correctly.
REQ-040 Busy start: second start pulse during DRAW -> ignored; exactly one done, with pixel count matching the first request.

Source files
------------

// File: rtl/text_render_ctrl_if.sv
// Glyph fetch and pixel write bus between the text renderer (master) and its
// text buffer, character decoder and pixel sink (slave).
interface text_render_ctrl_if #(
  parameter int unsigned LEN_W = 8
);
  logic             rd_en;
  logic [LEN_W-1:0] rd_addr;
  logic [6:0]       rd_data;
  logic [6:0]       dec_char;
  logic [127:0]     dec_pixels;
  logic             px_valid;
  logic [9:0]       px_x;
  logic [8:0]       px_y;
  logic             px_on;
  logic             px_ready;

  modport master (
    output rd_en, rd_addr, dec_char, px_valid, px_x, px_y, px_on,
    input  rd_data, dec_pixels, px_ready
  );

  modport slave (
    input  rd_en, rd_addr, dec_char, px_valid, px_x, px_y, px_on,
    output rd_data, dec_pixels, px_ready
  );
endinterface

// File: rtl/text_render_ctrl.sv
// Renders a string of 8x16 glyphs as a row-major stream of pixel writes,
// wrapping to the next text line at the right edge of the screen.
module text_render_ctrl #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned LEN_W    = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [9:0]          x0,
  input  logic [8:0]          y0,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  text_render_ctrl_if.master  bus
);

  localparam logic [10:0] ScreenW = 11'(SCREEN_W);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StDecode,
    StDraw,
    StDone
  } state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] index_q;
  logic [9:0]       cur_x_q;
  logic [8:0]       cur_y_q;
  logic [3:0]       row_q;
  logic [2:0]       col_q;
  logic [127:0]     bitmap_q;

  logic [2:0]       col_nxt;
  logic [3:0]       row_nxt;
  logic [10:0]      x_adv;
  logic [LEN_W:0]   index_inc;
  logic             last_px;
  logic             accept;

  always_comb begin
    col_nxt   = col_q + 3'd1;
    row_nxt   = (col_q == 3'd7) ? row_q + 4'd1 : row_q;
    x_adv     = {1'b0, cur_x_q} + 11'd8;
    index_inc = {1'b0, index_q} + (LEN_W+1)'(1);
    last_px   = (row_q == 4'd15) && (col_q == 3'd7);
    accept    = bus.px_valid && bus.px_ready;
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      len_q        <= '0;
      index_q      <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      row_q        <= '0;
      col_q        <= '0;
      bitmap_q     <= '0;
      done         <= 1'b0;
      bus.rd_en    <= 1'b0;
      bus.rd_addr  <= '0;
      bus.dec_char <= '0;
      bus.px_valid <= 1'b0;
      bus.px_x     <= '0;
      bus.px_y     <= '0;
      bus.px_on    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (len != '0) begin
              len_q       <= len;
              index_q     <= '0;
              cur_x_q     <= x0;
              cur_y_q     <= y0;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= '0;
              state_q     <= StFetch;
            end else begin
              done    <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StFetch: begin
          bus.rd_en <= 1'b0;
          state_q   <= StWait;
        end
        StWait: begin
          bus.dec_char <= bus.rd_data;
          state_q      <= StDecode;
        end
        StDecode: begin
          bitmap_q     <= bus.dec_pixels;
          row_q        <= '0;
          col_q        <= '0;
          bus.px_valid <= 1'b1;
          bus.px_x     <= cur_x_q;
          bus.px_y     <= cur_y_q;
          bus.px_on    <= bus.dec_pixels[127];
          state_q      <= StDraw;
        end
        StDraw: begin
          if (accept) begin
            if (last_px) begin
              bus.px_valid <= 1'b0;
              index_q      <= index_inc[LEN_W-1:0];
              if (x_adv >= ScreenW) begin
                cur_x_q <= '0;
                cur_y_q <= cur_y_q + 9'd16;
              end else begin
                cur_x_q <= x_adv[9:0];
              end
              if (index_inc < {1'b0, len_q}) begin
                bus.rd_en   <= 1'b1;
                bus.rd_addr <= index_inc[LEN_W-1:0];
                state_q     <= StFetch;
              end else begin
                done    <= 1'b1;
                state_q <= StDone;
              end
            end else begin
              // Present the next pixel; the bitmap is stored MSB-first, so
              // scan position p lives at bit 127-p, i.e. the inverted index.
              col_q     <= col_nxt;
              row_q     <= row_nxt;
              bus.px_x  <= cur_x_q + {7'd0, col_nxt};
              bus.px_y  <= cur_y_q + {5'd0, row_nxt};
              bus.px_on <= bitmap_q[~{row_nxt, col_nxt}];
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_text_render_ctrl.sv
// Directed bench for text_render_ctrl: buffer, glyph decoder and pixel sink
// models plus a handshake monitor feeding per-render stream checks.
module tb_text_render_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0;
  logic [9:0] x0 = '0;
  logic [8:0] y0 = '0;
  logic [7:0] len = '0;
  logic       busy;
  logic       done;

  text_render_ctrl_if #(.LEN_W(8)) bus_if ();

  text_render_ctrl #(
    .SCREEN_W(640),
    .LEN_W   (8)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .start (start),
    .x0    (x0),
    .y0    (y0),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic pix_model(input logic [6:0] ch, input int r, input int c);
    return ((r * c + int'(ch)) % 3) == 0;
  endfunction

  function automatic logic [127:0] font(input logic [6:0] ch);
    logic [127:0] v;
    v = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++)
        v[127 - (r * 8 + c)] = pix_model(ch, r, c);
    return v;
  endfunction

  logic [6:0] mem [0:7];
  initial for (int i = 0; i < 8; i++) mem[i] = 7'(65 + i);

  always @(posedge clk) if (bus_if.rd_en) bus_if.rd_data <= mem[bus_if.rd_addr[2:0]];
  always_comb bus_if.dec_pixels = font(bus_if.dec_char);

  bit rnd_ready = 1'b0;
  initial bus_if.px_ready = 1'b1;
  always @(negedge clk) bus_if.px_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;

  // Handshake monitor
  int         cyc = 0;
  int         hs_cnt, rd_cnt, done_cnt, first_rd, first_px, done_cyc;
  logic [9:0] qx [$];
  logic [8:0] qy [$];
  logic       qon [$];
  logic [7:0] rd_q [$];
  logic       prev_stall = 1'b0;
  logic [9:0] prev_x;
  logic [8:0] prev_y;
  logic       prev_on;

  always @(posedge clk) begin
    if (resetn) begin
      if (bus_if.rd_en) begin
        rd_cnt++;
        rd_q.push_back(bus_if.rd_addr);
        if (first_rd < 0) first_rd = cyc;
      end
      if (bus_if.px_valid && first_px < 0) first_px = cyc;
      if (prev_stall)
        check("hold", {bus_if.px_valid, bus_if.px_x, bus_if.px_y, bus_if.px_on},
              {1'b1, prev_x, prev_y, prev_on});
      if (bus_if.px_valid && bus_if.px_ready) begin
        hs_cnt++;
        qx.push_back(bus_if.px_x);
        qy.push_back(bus_if.px_y);
        qon.push_back(bus_if.px_on);
      end
      prev_stall = bus_if.px_valid && !bus_if.px_ready;
      prev_x     = bus_if.px_x;
      prev_y     = bus_if.px_y;
      prev_on    = bus_if.px_on;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
    cyc++;
  end

  int         start_cyc;
  logic [9:0] exp_x;
  logic [8:0] exp_y;
  int         exp_n;

  task automatic pulse_start(input logic [9:0] sx, input logic [8:0] sy, input int n);
    @(negedge clk);
    hs_cnt = 0; rd_cnt = 0; done_cnt = 0;
    first_rd = -1; first_px = -1; done_cyc = -1;
    qx.delete(); qy.delete(); qon.delete(); rd_q.delete();
    exp_x = sx; exp_y = sy; exp_n = n;
    x0 = sx; y0 = sy; len = 8'(n); start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit chk_lat);
    int t = 0;
    int bad = 0;
    int cx, cy, i;
    while (done_cnt == 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 64'(done_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
    check("done_once", 64'(done_cnt), 64'd1);
    check("busy_idle", 64'(busy), 64'd0);
    check("hs_count", 64'(hs_cnt), 64'(128 * exp_n));
    check("rd_count", 64'(rd_cnt), 64'(exp_n));
    for (int k = 0; k < exp_n && k < rd_q.size(); k++) check("rd_addr", 64'(rd_q[k]), 64'(k));
    if (chk_lat) begin
      check("done_lat", 64'(done_cyc - start_cyc), 64'(1 + 131 * exp_n));
      if (exp_n > 0) begin
        check("rd_lat", 64'(first_rd - start_cyc), 64'd1);
        check("px_lat", 64'(first_px - start_cyc), 64'd4);
      end
    end
    cx = int'(exp_x);
    cy = int'(exp_y);
    for (int k = 0; k < exp_n; k++) begin
      for (int p = 0; p < 128; p++) begin
        i = k * 128 + p;
        if (i >= qx.size()) bad++;
        else if (qx[i] != 10'(cx + p % 8) || qy[i] != 9'(cy + p / 8) ||
                 qon[i] != pix_model(mem[k], p / 8, p % 8)) bad++;
      end
      if (cx + 8 >= 640) begin
        cx = 0;
        cy = (cy + 16) % 512;
      end else begin
        cx = cx + 8;
      end
    end
    check("pix_stream", 64'(bad), 64'd0);
  endtask

  initial begin
    int t;
    #2 resetn = 1'b0;
    #1 check("reset_outs", {busy, done, bus_if.rd_en, bus_if.rd_addr, bus_if.dec_char,
                            bus_if.px_valid, bus_if.px_x, bus_if.px_y, bus_if.px_on}, 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Basic single glyph at the origin
    pulse_start(10'd0, 9'd0, 1);
    wait_done(1'b1);
    check("A_on_2_2", {qx[18], qy[18], qon[18]}, {10'd2, 9'd2, 1'b1});
    check("A_off_0_0", {qx[0], qy[0], qon[0]}, {10'd0, 9'd0, 1'b0});

    // Right-edge wrap onto the next text line
    pulse_start(10'd632, 9'd0, 2);
    wait_done(1'b1);
    check("wrap_c0_last", {qx[127], qy[127]}, {10'd639, 9'd15});
    check("wrap_c1_first", {qx[128], qy[128]}, {10'd0, 9'd16});
    check("wrap_c1_last", {qx[255], qy[255]}, {10'd7, 9'd31});

    // Zero length: straight to done
    pulse_start(10'd80, 9'd8, 0);
    wait_done(1'b1);

    // Random backpressure
    rnd_ready = 1'b1;
    pulse_start(10'd320, 9'd100, 2);
    wait_done(1'b0);
    rnd_ready = 1'b0;
    @(negedge clk);

    // Second start while drawing is ignored
    pulse_start(10'd48, 9'd32, 2);
    t = 0;
    while (hs_cnt < 20 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    x0 = 10'd200; len = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b1);

    // Reset in the middle of glyph 1 of 3
    pulse_start(10'd16, 9'd64, 3);
    t = 0;
    while (hs_cnt < 168 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("reach_draw1", 64'(hs_cnt >= 168 && busy), 64'd1);
    resetn = 1'b0;
    #1 check("midrst_outs", {busy, done, bus_if.rd_en, bus_if.rd_addr, bus_if.dec_char,
                             bus_if.px_valid, bus_if.px_x, bus_if.px_y, bus_if.px_on}, 64'd0);
    repeat (4) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    resetn = 1'b1;

    pulse_start(10'd8, 9'd40, 2);
    wait_done(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
